// File: rtl/hist_remap_pipeline.sv
// hist_remap_pipeline
//   Final histogram-equalizer stage. Phase A turns the 256 CDF entries held in the
//   scratchpad into an 8-bit remap table, written back to the scratchpad. Phase B
//   streams image words from m1 through that table and writes the equalized words
//   to m4, 16 pixels per 128-bit word.
//   Optional build macro HIST_REMAP_ROUND_EN: round-half-up instead of truncating
//   the map division. Cycle timing is the same either way.
module hist_remap_pipeline #(
    parameter int PIXEL_WORDS = 4,
    parameter int CDF_W       = 20
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CDF_W-1:0]   cdf_min,
    input  logic               input_base_offset,
    output logic [15:0]        m1ReadAddr,
    input  logic [127:0]       m1ReadBus,
    output logic [15:0]        spReadAddr,
    input  logic [127:0]       spReadBus,
    output logic               spWE,
    output logic [15:0]        spWriteAddr,
    output logic [127:0]       spWriteBus,
    output logic               m4WE,
    output logic [15:0]        m4WriteAddr,
    output logic [127:0]       m4WriteBus,
    output logic               busy,
    output logic               done
);

    localparam int DEN_W  = CDF_W + 1;   // N - cdf_min
    localparam int NUM_W  = CDF_W + 8;   // (cdf - cdf_min) * 255
    localparam int REM_W  = DEN_W + 8;   // numerator incl. rounding bias, and den << 8
    localparam int WORD_W = (PIXEL_WORDS > 1) ? $clog2(PIXEL_WORDS) : 1;
    localparam logic [DEN_W-1:0]  N_PIX     = DEN_W'(PIXEL_WORDS * 16);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(PIXEL_WORDS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_MAP_RD, S_MAP_WAIT, S_MAP_DIV, S_MAP_WR,
        S_IMG_RD, S_IMG_WAIT, S_IMG_LOOK, S_IMG_WR, S_DONE
    } state_t;

    state_t              state_q;
    logic [CDF_W-1:0]    cmin_q;
    logic [DEN_W-1:0]    den_q;
    logic                off_q;
    logic [7:0]          bin_q;
    logic [WORD_W-1:0]   word_q;
    logic [4:0]          pix_q;
    logic [2:0]          div_cnt_q;
    logic [REM_W-1:0]    rem_q;
    logic [REM_W-1:0]    dsh_q;
    logic [7:0]          quo_q;
    logic                zero_q;
    logic                ovf_q;
    logic [7:0]          map_q;
    logic [127:0]        img_q;
    logic [127:0]        out_q;

    logic [CDF_W-1:0]    cdf_rd;
    logic [CDF_W-1:0]    diff;
    logic [NUM_W-1:0]    num_d;
    logic [REM_W-1:0]    numr_d;
    logic                zero_d;
    logic                ovf_d;
    logic                div_ge;
    logic [REM_W-1:0]    rem_d;
    logic [7:0]          quo_d;
    logic [7:0]          pix_sel;
    logic [3:0]          lane_idx;
    logic                unused_bits;

    // Numerator / divide datapath shared by the map-building states
    assign cdf_rd = spReadBus[CDF_W-1:0];
    assign diff   = cdf_rd - cmin_q;
    assign num_d  = NUM_W'(diff) * NUM_W'(255);
`ifdef HIST_REMAP_ROUND_EN
    assign numr_d = REM_W'(num_d) + REM_W'(den_q >> 1);
`else
    assign numr_d = REM_W'(num_d);
`endif
    assign zero_d = (cdf_rd <= cmin_q) || (den_q == '0);
    // Quotient >= 256 cannot come out of an 8-step divide, so it is flagged up front
    assign ovf_d  = numr_d >= {den_q, 8'b0};
    assign div_ge = rem_q >= dsh_q;
    assign rem_d  = div_ge ? (rem_q - dsh_q) : rem_q;
    assign quo_d  = {quo_q[6:0], div_ge};

    // Pixel being looked up this cycle and the lane its result lands in one cycle later
    assign pix_sel  = img_q[{pix_q[3:0], 3'b000} +: 8];
    assign lane_idx = pix_q[3:0] - 4'd1;

    assign unused_bits = ^spReadBus[127:CDF_W];

    // Sequencer: map build over 256 bins, then remap of every image word
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cmin_q    <= '0;
            den_q     <= '0;
            off_q     <= 1'b0;
            bin_q     <= '0;
            word_q    <= '0;
            pix_q     <= '0;
            div_cnt_q <= '0;
            rem_q     <= '0;
            dsh_q     <= '0;
            quo_q     <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            map_q     <= '0;
            img_q     <= '0;
            out_q     <= '0;
        end else if (state_q != S_IDLE && !start) begin
            // Abort: nothing is resumed, the next start rebuilds the map from bin 0
            state_q   <= S_IDLE;
            bin_q     <= '0;
            word_q    <= '0;
            pix_q     <= '0;
            div_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cmin_q  <= cdf_min;
                        den_q   <= N_PIX - DEN_W'(cdf_min);
                        off_q   <= input_base_offset;
                        bin_q   <= '0;
                        word_q  <= '0;
                        state_q <= S_MAP_RD;
                    end
                end
                S_MAP_RD: state_q <= S_MAP_WAIT;
                S_MAP_WAIT: begin
                    rem_q     <= numr_d;
                    dsh_q     <= {1'b0, den_q, 7'b0};
                    quo_q     <= '0;
                    zero_q    <= zero_d;
                    ovf_q     <= ovf_d;
                    div_cnt_q <= '0;
                    state_q   <= S_MAP_DIV;
                end
                S_MAP_DIV: begin
                    rem_q     <= rem_d;
                    dsh_q     <= dsh_q >> 1;
                    quo_q     <= quo_d;
                    div_cnt_q <= div_cnt_q + 3'd1;
                    if (div_cnt_q == 3'd7) begin
                        map_q   <= zero_q ? 8'd0 : (ovf_q ? 8'd255 : quo_d);
                        state_q <= S_MAP_WR;
                    end
                end
                S_MAP_WR: begin
                    if (bin_q == 8'd255) begin
                        bin_q   <= '0;
                        state_q <= S_IMG_RD;
                    end else begin
                        bin_q   <= bin_q + 8'd1;
                        state_q <= S_MAP_RD;
                    end
                end
                S_IMG_RD: state_q <= S_IMG_WAIT;
                S_IMG_WAIT: begin
                    img_q   <= m1ReadBus;
                    out_q   <= '0;
                    pix_q   <= '0;
                    state_q <= S_IMG_LOOK;
                end
                S_IMG_LOOK: begin
                    if (pix_q != 5'd0) begin
                        out_q[{lane_idx, 3'b000} +: 8] <= spReadBus[7:0];
                    end
                    if (pix_q == 5'd16) begin
                        pix_q   <= '0;
                        state_q <= S_IMG_WR;
                    end else begin
                        pix_q <= pix_q + 5'd1;
                    end
                end
                S_IMG_WR: begin
                    if (word_q == LAST_WORD) begin
                        state_q <= S_DONE;
                    end else begin
                        word_q  <= word_q + WORD_W'(1);
                        state_q <= S_IMG_RD;
                    end
                end
                S_DONE:  state_q <= S_DONE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Memory-side buses are decoded from state and stay zero outside their own states
    always_comb begin
        m1ReadAddr  = '0;
        spReadAddr  = '0;
        spWE        = 1'b0;
        spWriteAddr = '0;
        spWriteBus  = '0;
        m4WE        = 1'b0;
        m4WriteAddr = '0;
        m4WriteBus  = '0;
        case (state_q)
            S_MAP_RD:   spReadAddr = {off_q, 7'b0, bin_q};
            S_MAP_WR: begin
                spWE        = 1'b1;
                spWriteAddr = {off_q, 6'b0, 1'b1, bin_q};
                spWriteBus  = {120'b0, map_q};
            end
            S_IMG_RD:   m1ReadAddr = 16'(word_q);
            S_IMG_LOOK: begin
                if (!pix_q[4]) spReadAddr = {off_q, 6'b0, 1'b1, pix_sel};
            end
            S_IMG_WR: begin
                m4WE        = 1'b1;
                m4WriteAddr = 16'(word_q);
                m4WriteBus  = out_q;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_hist_remap_pipeline.sv
// Bench for hist_remap_pipeline: memory models for m1/scratchpad/m4, a table of
// scenarios checked against an arithmetic map model, plus abort and async-reset sequences.
`timescale 1ns/1ps
module tb_hist_remap_pipeline;

    localparam int PW   = 4;
    localparam int NPIX = PW * 16;
    localparam int LAT  = 256 * 11 + PW * 20 + 1;

    logic         clock = 1'b0;
    logic         rst_n;
    logic         start;
    logic [19:0]  cdf_min;
    logic         input_base_offset;
    logic [15:0]  m1ReadAddr;
    logic [127:0] m1ReadBus;
    logic [15:0]  spReadAddr;
    logic [127:0] spReadBus;
    logic         spWE;
    logic [15:0]  spWriteAddr;
    logic [127:0] spWriteBus;
    logic         m4WE;
    logic [15:0]  m4WriteAddr;
    logic [127:0] m4WriteBus;
    logic         busy;
    logic         done;

    hist_remap_pipeline #(.PIXEL_WORDS(PW), .CDF_W(20)) dut (
        .clock(clock), .rst_n(rst_n), .start(start), .cdf_min(cdf_min),
        .input_base_offset(input_base_offset),
        .m1ReadAddr(m1ReadAddr), .m1ReadBus(m1ReadBus),
        .spReadAddr(spReadAddr), .spReadBus(spReadBus),
        .spWE(spWE), .spWriteAddr(spWriteAddr), .spWriteBus(spWriteBus),
        .m4WE(m4WE), .m4WriteAddr(m4WriteAddr), .m4WriteBus(m4WriteBus),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Memories: CDF area and m1 are loaded by the stimulus, map area and m4 by the DUT
    logic [127:0] cdf_mem [512];
    logic [127:0] map_mem [512];
    logic [127:0] m1_mem  [16];
    logic [127:0] m4_mem  [16];
    int           m4_we_cnt [16];
    int           m4_we_total;
    int           sp_we_cnt;
    int           bad_cnt;
    logic         clr_mon = 1'b0;

    always @(posedge clock) begin
        m1ReadBus <= m1_mem[m1ReadAddr[3:0]];
        if (spReadAddr[14:8] == 7'd0)      spReadBus <= cdf_mem[{spReadAddr[15], spReadAddr[7:0]}];
        else if (spReadAddr[14:8] == 7'd1) spReadBus <= map_mem[{spReadAddr[15], spReadAddr[7:0]}];
        else                               spReadBus <= '0;
        if (clr_mon) begin
            for (int i = 0; i < 512; i++) map_mem[i] <= '0;
            for (int i = 0; i < 16; i++) begin
                m4_mem[i]    <= '0;
                m4_we_cnt[i] <= 0;
            end
            m4_we_total <= 0;
            sp_we_cnt   <= 0;
            bad_cnt     <= 0;
        end else begin
            if (spWE) begin
                map_mem[{spWriteAddr[15], spWriteAddr[7:0]}] <= spWriteBus;
                sp_we_cnt <= sp_we_cnt + 1;
            end
            if (m4WE) begin
                m4_mem[m4WriteAddr[3:0]]    <= m4WriteBus;
                m4_we_cnt[m4WriteAddr[3:0]] <= m4_we_cnt[m4WriteAddr[3:0]] + 1;
                m4_we_total <= m4_we_total + 1;
            end
            if ((spWE && spWriteAddr[14:8] != 7'd1) || (m4WE && m4WriteAddr >= 16'(PW)) ||
                ((spWE || m4WE) && !busy))
                bad_cnt <= bad_cnt + 1;
        end
    end

    typedef struct {
        int   cmin;
        logic off;
        int   cdf_mode;   // 0: CDF(v)=v from cmin up, 1: random ramp from cmin to N
        int   img_mode;   // 0: all 0x40, 1: word0 ramp 0..15, 2: random
        int   probe_bin;
        int   probe_exp;
    } scen_t;

    scen_t        scen [6];
    int           cdf_v [256];
    logic [7:0]   map_exp [256];
    logic [127:0] img_w [PW];
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Map value from the equalization formula, computed with wide integers
    function automatic logic [7:0] ref_map(input longint cdf, input longint cmin);
        longint den, num, q;
        den = (longint'(NPIX) - cmin) & 64'h1F_FFFF;
        if (cdf <= cmin || den == 0) return 8'd0;
        num = (cdf - cmin) * 255;
`ifdef HIST_REMAP_ROUND_EN
        num = num + den / 2;
`endif
        q = num / den;
        if (q > 255) q = 255;
        return 8'(q);
    endfunction

    task automatic clear_mon();
        clr_mon = 1'b1;
        @(posedge clock); #1;
        clr_mon = 1'b0;
    endtask

    task automatic setup(input int idx);
        int k;
        logic [127:0] r;
        k = $urandom_range(1, 50);
        for (int v = 0; v < 256; v++) begin
            if (scen[idx].cdf_mode == 0) cdf_v[v] = (v >= scen[idx].cmin) ? v : 0;
            else cdf_v[v] = (v < k) ? 0 :
                 scen[idx].cmin + (NPIX - scen[idx].cmin) * (v - k) / (255 - k);
            r = {$urandom, $urandom, $urandom, $urandom};
            r[19:0] = 20'(cdf_v[v]);
            cdf_mem[int'(scen[idx].off) * 256 + v] = r;
            map_exp[v] = ref_map(longint'(cdf_v[v]), longint'(scen[idx].cmin));
        end
        for (int w = 0; w < PW; w++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            if (scen[idx].img_mode == 0) r = {16{8'h40}};
            if (scen[idx].img_mode == 1 && w == 0)
                for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'(i);
            img_w[w]  = r;
            m1_mem[w] = r;
        end
        cdf_min           = 20'(scen[idx].cmin);
        input_base_offset = scen[idx].off;
    endtask

    task automatic run_full(input int idx);
        int n;
        int bad_map;
        int bad_we;
        logic [127:0] exp_w;
        string tag;
        tag = $sformatf("s%0d", idx);
        clear_mon();
        @(posedge clock); #1;
        start = 1'b1;
        n = -1;
        for (int c = 1; c <= 4000; c++) begin
            @(posedge clock); #1;
            if (c == 1) cdf_min = 20'($urandom);   // must have been latched already
            if (done) begin
                n = c;
                break;
            end
        end
        check({tag, " start-to-done cycles"}, 128'(n), 128'(LAT));
        repeat (3) @(posedge clock);
        #1;
        check({tag, " done held {busy,done}"}, 128'({busy, done}), 128'(2'b01));
        bad_map = 0;
        for (int v = 0; v < 256; v++)
            if (map_mem[int'(scen[idx].off) * 256 + v] !== {120'b0, map_exp[v]}) bad_map++;
        check({tag, " map entries wrong"}, 128'(bad_map), 128'(0));
        check({tag, " probe map"}, map_mem[int'(scen[idx].off) * 256 + scen[idx].probe_bin],
              128'(scen[idx].probe_exp));
        check({tag, " spWE pulses"}, 128'(sp_we_cnt), 128'(256));
        bad_we = 0;
        for (int w = 0; w < 16; w++) if (m4_we_cnt[w] != ((w < PW) ? 1 : 0)) bad_we++;
        check({tag, " m4 words not written once"}, 128'(bad_we), 128'(0));
        check({tag, " stray writes"}, 128'(bad_cnt), 128'(0));
        for (int w = 0; w < PW; w++) begin
            for (int i = 0; i < 16; i++) exp_w[8*i +: 8] = map_exp[img_w[w][8*i +: 8]];
            check($sformatf("%s m4 word %0d", tag, w), m4_mem[w], exp_w);
        end
        start = 1'b0;
        @(posedge clock); #1;
        check({tag, " idle after start low"}, 128'({busy, done}), 128'(2'b00));
    endtask

    function automatic logic [127:0] outs_or();
        return 128'({busy, done, spWE, m4WE, |spReadAddr, |spWriteAddr, |spWriteBus,
                     |m1ReadAddr, |m4WriteAddr, |m4WriteBus});
    endfunction

    initial begin
        int found;
        logic [127:0] w0, w1;
        scen[0] = '{cmin: 4,  off: 1'b0, cdf_mode: 0, img_mode: 0, probe_bin: 64,  probe_exp: 255};
`ifdef HIST_REMAP_ROUND_EN
        scen[1] = '{cmin: 4,  off: 1'b1, cdf_mode: 0, img_mode: 1, probe_bin: 34,  probe_exp: 128};
`else
        scen[1] = '{cmin: 4,  off: 1'b1, cdf_mode: 0, img_mode: 1, probe_bin: 34,  probe_exp: 127};
`endif
        scen[2] = '{cmin: 64, off: 1'b0, cdf_mode: 0, img_mode: 2, probe_bin: 200, probe_exp: 0};
        scen[3] = '{cmin: 4,  off: 1'b0, cdf_mode: 0, img_mode: 1, probe_bin: 4,   probe_exp: 0};
        scen[4] = '{cmin: int'($urandom_range(1, 63)), off: 1'b1, cdf_mode: 1, img_mode: 2,
                    probe_bin: 255, probe_exp: 255};
        scen[5] = '{cmin: int'($urandom_range(1, 63)), off: 1'b0, cdf_mode: 1, img_mode: 2,
                    probe_bin: 0, probe_exp: 0};

        rst_n = 1'b0;
        start = 1'b0;
        cdf_min = '0;
        input_base_offset = 1'b0;
        for (int i = 0; i < 16; i++) m1_mem[i] = '0;
        for (int i = 0; i < 512; i++) cdf_mem[i] = '0;
        clear_mon();
        repeat (2) @(posedge clock);
        #1;
        check("reset outputs", outs_or(), 128'(0));
        rst_n = 1'b1;
        @(posedge clock); #1;
        check("idle after reset busy", 128'(busy), 128'(0));

        for (int s = 0; s < 6; s++) begin
            setup(s);
            run_full(s);
        end

        // Abort while word 2 is being fetched, then rerun from scratch
        setup(1);
        clear_mon();
        start = 1'b1;
        found = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clock); #1;
            if (busy && m1ReadAddr == 16'd2) begin
                found = 1;
                break;
            end
        end
        check("abort reached word 2", 128'(found), 128'(1));
        start = 1'b0;
        @(posedge clock); #1;
        check("abort next cycle idle", outs_or(), 128'(0));
        repeat (20) @(posedge clock);
        #1;
        check("abort m4 writes", 128'(m4_we_total), 128'(2));
        w0 = m4_mem[0];
        w1 = m4_mem[1];
        run_full(1);
        check("rerun word 0 matches", m4_mem[0], w0);
        check("rerun word 1 matches", m4_mem[1], w1);

        // Asynchronous reset in the middle of a divide
        setup(0);
        clear_mon();
        start = 1'b1;
        repeat (5) @(posedge clock);
        #2;
        check("busy before reset", 128'(busy), 128'(1));
        rst_n = 1'b0;
        #1;
        check("async reset outputs", outs_or(), 128'(0));
        start = 1'b0;
        @(posedge clock); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("busy low until start", 128'(busy), 128'(0));
        start = 1'b1;
        @(posedge clock); #1;
        check("busy after start", 128'(busy), 128'(1));
        start = 1'b0;
        @(posedge clock); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
